// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the serial pattern lock.
//   state_e    : FSM state encodings (IDLE=00, OPEN=01, LOCKOUT=10; 11 unused)
//   tmr_width  : width helper for the shared OPEN/LOCKOUT timer
//   TRY_W/TMR_W: widths for the default parameter set
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OPEN    = 2'b01,
        ST_LOCKOUT = 2'b10
    } state_e;

    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_OPEN_CYC    = 8;
    localparam int DEF_LOCKOUT_CYC = 16;

    // Timer width for max(a,b); at least one bit so a 1-cycle period still builds.
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int TRY_W = $clog2(DEF_MAX_TRIES + 1);
    localparam int TMR_W = tmr_width(DEF_OPEN_CYC, DEF_LOCKOUT_CYC);

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter shared by the OPEN and LOCKOUT periods.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load strobe, takes priority over counting
//   load_val  : value loaded on load
//   done      : high while the count is zero
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next-count: load wins, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != ZERO) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == ZERO);

endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: serial pattern lock sequencer.
//   clk, rst    : clock, synchronous active-high reset
//   bit_in      : code bit, taken when bit_vld=1 in IDLE (first bit ends up MSB)
//   bit_vld     : qualifies bit_in
//   enter       : end-of-entry strobe, judges the current entry
//   unlock      : door release, OPEN_CYC cycles after a match
//   alarm       : high for LOCKOUT_CYC cycles once the try budget runs out
//   busy        : high in OPEN or LOCKOUT (inputs ignored)
//   tries_left  : remaining failed attempts before lockout
//   state_o     : 00 IDLE, 01 OPEN, 10 LOCKOUT
module code_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                CODE_W      = 3,
    parameter logic [CODE_W-1:0] CODE        = 3'b110,
    parameter int                MAX_TRIES   = 3,
    parameter int                OPEN_CYC    = 8,
    parameter int                LOCKOUT_CYC = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bit_in,
    input  logic                             bit_vld,
    input  logic                             enter,
    output logic                             unlock,
    output logic                             alarm,
    output logic                             busy,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic [1:0]                       state_o
);

    localparam int TRY_BITS = $clog2(MAX_TRIES + 1);
    localparam int TMR_BITS = tmr_width(OPEN_CYC, LOCKOUT_CYC);
    localparam int CNT_BITS = $clog2(CODE_W + 1);

    localparam logic [TRY_BITS-1:0] TRIES_MAX = TRY_BITS'(MAX_TRIES);
    localparam logic [TRY_BITS-1:0] TRY_ONE   = TRY_BITS'(1);
    localparam logic [TRY_BITS-1:0] TRY_ZERO  = {TRY_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_FULL  = CNT_BITS'(CODE_W);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [TMR_BITS-1:0] OPEN_LOAD = TMR_BITS'(OPEN_CYC - 1);
    localparam logic [TMR_BITS-1:0] LOCK_LOAD = TMR_BITS'(LOCKOUT_CYC - 1);

    logic [1:0]          state_q, state_d;
    logic [CODE_W-1:0]   sr_q, sr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unlock_q, unlock_d;
    logic                alarm_q, alarm_d;
    logic                busy_q, busy_d;
    logic [TRY_BITS-1:0] tries_q, tries_d;

    logic                tmr_load_s;
    logic [TMR_BITS-1:0] tmr_val_s;
    logic                tmr_done_s;
    logic                match_s;

    // An entry is good only with exactly CODE_W bits and no extra bit seen.
    assign match_s = (cnt_q == CNT_FULL) && !ovf_q && (sr_q == CODE);

    lock_timer #(
        .W (TMR_BITS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // FSM next-state, entry capture and output decode.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unlock_d   = unlock_q;
        alarm_d    = alarm_q;
        busy_d     = busy_q;
        tries_d    = tries_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = OPEN_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (enter) begin
                    // A bit_vld arriving with enter is dropped; entry always clears.
                    sr_d  = {CODE_W{1'b0}};
                    cnt_d = CNT_ZERO;
                    ovf_d = 1'b0;
                    if (match_s) begin
                        state_d    = ST_OPEN;
                        unlock_d   = 1'b1;
                        busy_d     = 1'b1;
                        tries_d    = TRIES_MAX;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = OPEN_LOAD;
                    end else if (tries_q > TRY_ONE) begin
                        tries_d = tries_q - TRY_ONE;
                    end else begin
                        state_d    = ST_LOCKOUT;
                        alarm_d    = 1'b1;
                        busy_d     = 1'b1;
                        tries_d    = TRY_ZERO;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = LOCK_LOAD;
                    end
                end else if (bit_vld) begin
                    sr_d = {sr_q[CODE_W-2:0], bit_in};
                    if (cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (tmr_done_s) begin
                    state_d  = ST_IDLE;
                    unlock_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done_s) begin
                    state_d = ST_IDLE;
                    alarm_d = 1'b0;
                    busy_d  = 1'b0;
                    tries_d = TRIES_MAX;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                // Unused encoding: fall back to a clean IDLE.
                state_d  = ST_IDLE;
                sr_d     = {CODE_W{1'b0}};
                cnt_d    = CNT_ZERO;
                ovf_d    = 1'b0;
                unlock_d = 1'b0;
                alarm_d  = 1'b0;
                busy_d   = 1'b0;
                tries_d  = TRIES_MAX;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sr_q     <= {CODE_W{1'b0}};
            cnt_q    <= CNT_ZERO;
            ovf_q    <= 1'b0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            busy_q   <= 1'b0;
            tries_q  <= TRIES_MAX;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unlock_q <= unlock_d;
            alarm_q  <= alarm_d;
            busy_q   <= busy_d;
            tries_q  <= tries_d;
        end
    end

    assign unlock     = unlock_q;
    assign alarm      = alarm_q;
    assign busy       = busy_q;
    assign tries_left = tries_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: self-checking bench for code_lock_ctrl with default
// parameters (code 110, 3 tries, 8-cycle open, 16-cycle lockout).
module tb_code_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic       enter = 1'b0;
    logic       unlock, alarm, busy;
    logic [1:0] tries_left, state_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       unlock;
        logic       alarm;
        logic [1:0] state;
        logic [1:0] tries;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the entry / try bookkeeping.
    localparam logic [2:0] CODE = 3'b110;
    int         m_mode;   // 0 idle, 1 open, 2 lockout
    int         m_tries;
    int         m_cnt;
    logic [2:0] m_sr;
    logic       m_ovf;

    always #5 clk = ~clk;

    code_lock_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_vld    (bit_vld),
        .enter      (enter),
        .unlock     (unlock),
        .alarm      (alarm),
        .busy       (busy),
        .tries_left (tries_left),
        .state_o    (state_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_sr  = 3'b000;
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; enter = 1'b0;
        tick();
        rst = 1'b0;
        m_mode = 0; m_tries = 3;
        model_clear();
    endtask

    task automatic drive_bit(input logic b);
        bit_vld = 1'b1; bit_in = b;
        if (m_mode == 0) begin
            m_sr = {m_sr[1:0], b};
            if (m_cnt == 3) m_ovf = 1'b1;
            else m_cnt++;
        end
        tick();
        bit_vld = 1'b0; bit_in = 1'b0;
    endtask

    // Pulse enter (optionally with a simultaneous bit) and push the expected outcome.
    task automatic do_enter(input logic vld, input logic b);
        exp_t e;
        int   st;
        enter = 1'b1; bit_vld = vld; bit_in = b;
        if (m_mode == 0) begin
            if (m_cnt == 3 && !m_ovf && m_sr == CODE) begin
                m_mode = 1; m_tries = 3;
            end else if (m_tries > 1) begin
                m_tries--;
            end else begin
                m_mode = 2; m_tries = 0;
            end
            model_clear();
        end
        st = m_mode;
        e.unlock = (m_mode == 1);
        e.alarm  = (m_mode == 2);
        e.state  = st[1:0];
        e.tries  = m_tries[1:0];
        exp_q.push_back(e);
        tick();
        enter = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;
    endtask

    task automatic enter_code(input logic [2:0] c);
        drive_bit(c[2]); drive_bit(c[1]); drive_bit(c[0]);
        do_enter(1'b0, 1'b0);
    endtask

    // Count consecutive high cycles of unlock (sel=0) or alarm (sel=1), bounded.
    task automatic measure(input int sel, output int n);
        n = 0;
        while (((sel == 0) ? unlock : alarm) && n < 100) begin
            n++;
            tick();
        end
        if (sel == 1) m_tries = 3;
        m_mode = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({unlock, alarm, busy, tries_left, state_o} !== {1'b0, 1'b0, 1'b0, 2'd3, 2'b00}) begin
            errors++;
            $display("FAIL reset: got u/a/b/t/s=%b%b%b %0d %b want 000 3 00",
                     unlock, alarm, busy, tries_left, state_o);
        end
    endtask

    task automatic test_unlock();
        exp_t e;
        int   n;
        do_reset();
        enter_code(3'b110);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left, busy} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL t1_enter: got %b%b %b %0d busy=%b want %b busy=1",
                     unlock, alarm, state_o, tries_left, busy, e);
        end
        measure(0, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL t1_pulse: unlock len %0d want 8", n);
        end
        checks++;
        if ({state_o, tries_left, busy} !== {2'b00, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL t1_exit: state=%b tries=%0d busy=%b want 00 3 0", state_o, tries_left, busy);
        end
    endtask

    task automatic test_wrong_then_right();
        exp_t e;
        int   n;
        do_reset();
        enter_code(3'b101);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t2_miss: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
        enter_code(3'b110);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t2_hit: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
        measure(0, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL t2_pulse: unlock len %0d want 8", n);
        end
    endtask

    task automatic test_lockout();
        exp_t e;
        int   n;
        int   k;
        logic bad;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            enter_code(3'b000);
            e = exp_q.pop_front();
            checks++;
            if ({unlock, alarm, state_o, tries_left} !== e) begin
                errors++;
                $display("FAIL t3_miss%0d: got %b%b %b %0d want %b",
                         i, unlock, alarm, state_o, tries_left, e);
            end
        end
        // Alarm period with a correct code entered part-way through.
        n = 0; k = 0; bad = 1'b0;
        while (alarm && n < 100) begin
            n++;
            if (unlock !== 1'b0 || state_o !== 2'b10) bad = 1'b1;
            bit_vld = (k < 3); enter = (k == 3);
            bit_in  = (k < 2);
            k++;
            tick();
            bit_vld = 1'b0; enter = 1'b0; bit_in = 1'b0;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL t3_alarm_len: got %0d want 16", n);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL t3_lock_ignore: unlock/state disturbed during lockout got %b want 0", bad);
        end
        checks++;
        if ({unlock, alarm, busy, state_o, tries_left} !== {1'b0, 1'b0, 1'b0, 2'b00, 2'd3}) begin
            errors++;
            $display("FAIL t3_exit: got %b%b%b %b %0d want 000 00 3",
                     unlock, alarm, busy, state_o, tries_left);
        end
        m_mode = 0; m_tries = 3;
        enter_code(3'b110);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t3_relock_hit: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
        measure(0, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL t3_pulse: unlock len %0d want 8", n);
        end
    endtask

    task automatic test_overflow_empty();
        exp_t e;
        do_reset();
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
        do_enter(1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t4_overflow: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
        do_enter(1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t4_empty: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        drive_bit(1'b1); drive_bit(1'b1);
        do_enter(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t5_discard: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
    endtask

    task automatic test_reset_mid_open();
        exp_t e;
        int   n;
        do_reset();
        enter_code(3'b110);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t6_hit: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_mode = 0; m_tries = 3; model_clear();
        checks++;
        if ({unlock, alarm, busy, state_o, tries_left} !== {1'b0, 1'b0, 1'b0, 2'b00, 2'd3}) begin
            errors++;
            $display("FAIL t6_abort: got %b%b%b %b %0d want 000 00 3",
                     unlock, alarm, busy, state_o, tries_left);
        end
        enter_code(3'b110);
        e = exp_q.pop_front();
        checks++;
        if ({unlock, alarm, state_o, tries_left} !== e) begin
            errors++;
            $display("FAIL t6_rehit: got %b%b %b %0d want %b", unlock, alarm, state_o, tries_left, e);
        end
        measure(0, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL t6_pulse: unlock len %0d want 8", n);
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_wrong_then_right();
        test_lockout();
        test_overflow_empty();
        test_back_to_back();
        test_reset_mid_open();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
